// File: rtl/bin_to_digit_writer.sv
// Binary to BCD converter (one double-dabble step per clock) that then streams
// each decimal digit, least significant first, to a seven-segment display writer.
module bin_to_digit_writer #(
    parameter int IN_W   = 26,
    parameter int DIGITS = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [IN_W-1:0] bin,
    output logic            busy,
    output logic            done,
    output logic            write,
    output logic [3:0]      num,
    output logic [2:0]      sel
);

    localparam int BCD_W  = 4 * DIGITS;
    localparam int CNT_MX = (IN_W > DIGITS) ? IN_W : DIGITS;
    localparam int STEP_W = $clog2(CNT_MX) + 1;
    localparam logic [STEP_W-1:0] LAST_CONV  = STEP_W'(IN_W - 1);
    localparam logic [STEP_W-1:0] LAST_WRITE = STEP_W'(DIGITS - 1);

    typedef enum logic [1:0] {IDLE, CONVERT, WRITE, DONE} state_t;

    state_t            state, state_n;
    logic [STEP_W-1:0] step, step_n;
    logic [IN_W-1:0]   sr, sr_n;
    logic [BCD_W-1:0]  bcd, bcd_n, bcd_adj;
    logic              busy_n, done_n, write_n;
    logic [3:0]        num_n;
    logic [2:0]        sel_n;

    function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] v);
        logic [BCD_W-1:0] r;
        r = v;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] >= 4'd5)
                r[4*i +: 4] = v[4*i +: 4] + 4'd3;
        end
        return r;
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            step  <= '0;
            sr    <= '0;
            bcd   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            write <= 1'b0;
            num   <= 4'd0;
            sel   <= 3'd0;
        end else begin
            state <= state_n;
            step  <= step_n;
            sr    <= sr_n;
            bcd   <= bcd_n;
            busy  <= busy_n;
            done  <= done_n;
            write <= write_n;
            num   <= num_n;
            sel   <= sel_n;
        end
    end

    always_comb begin
        state_n = state;
        step_n  = step;
        sr_n    = sr;
        bcd_n   = bcd;
        write_n = 1'b0;
        done_n  = 1'b0;
        num_n   = num;
        sel_n   = sel;
        bcd_adj = add3(bcd);

        case (state)
            IDLE: begin
                if (start) begin
                    state_n = CONVERT;
                    step_n  = '0;
                    sr_n    = bin;
                    bcd_n   = '0;
                end
            end
            CONVERT: begin
                bcd_n = {bcd_adj[BCD_W-2:0], sr[IN_W-1]};
                sr_n  = {sr[IN_W-2:0], 1'b0};
                // The last step already presents digit 0 so the first write
                // appears the cycle right after the final shift.
                if (step == LAST_CONV) begin
                    state_n = WRITE;
                    step_n  = '0;
                    write_n = 1'b1;
                    sel_n   = 3'd0;
                    num_n   = bcd_n[3:0];
                end else begin
                    step_n = step + 1'b1;
                end
            end
            WRITE: begin
                if (step == LAST_WRITE) begin
                    state_n = DONE;
                    step_n  = '0;
                    done_n  = 1'b1;
                end else begin
                    step_n  = step + 1'b1;
                    write_n = 1'b1;
                    sel_n   = sel + 3'd1;
                    num_n   = bcd[4*int'(step_n) +: 4];
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        busy_n = (state_n != IDLE);
    end

endmodule

// File: tb/tb_bin_to_digit_writer.sv
// Directed bench for bin_to_digit_writer: digit streams, timing, start/bin
// isolation, asynchronous reset abort and a downstream display model.
module tb_bin_to_digit_writer;

    logic        clk;
    logic        reset;
    logic        start;
    logic [25:0] bin;
    logic        busy, done, write;
    logic [3:0]  num;
    logic [2:0]  sel;

    // 27-bit instance: 90817263 exceeds 26 bits but still fits 8 digits
    logic        start1;
    logic [26:0] bin1;
    logic        busy1, done1, write1;
    logic [3:0]  num1;
    logic [2:0]  sel1;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    int          wcnt = 0;
    int          done_cnt = 0;
    int          done_cyc = 0;
    int          busy_cnt = 0;
    logic [2:0]  wsel [0:127];
    logic [3:0]  wnum [0:127];
    int          wcyc [0:127];

    int          done1_cnt = 0;
    logic [3:0]  disp [0:7];

    bin_to_digit_writer dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .write (write),
        .num   (num),
        .sel   (sel)
    );

    bin_to_digit_writer #(.IN_W(27), .DIGITS(8)) dut1 (
        .clk   (clk),
        .reset (reset),
        .start (start1),
        .bin   (bin1),
        .busy  (busy1),
        .done  (done1),
        .write (write1),
        .num   (num1),
        .sel   (sel1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (busy) busy_cnt++;
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (write) begin
            if (wcnt < 128) begin
                wsel[wcnt] = sel;
                wnum[wcnt] = num;
                wcyc[wcnt] = cyc;
            end
            wcnt++;
        end
    end

    // Seven-segment display register file fed by the writer strobes
    always @(negedge clk) begin
        if (write1) disp[sel1] = num1;
        if (done1) done1_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic run_conv(input string nm, input logic [25:0] val,
                            input logic [31:0] exp, input bit glitch);
        int w0, d0, b0, acc;
        w0 = wcnt;
        d0 = done_cnt;
        b0 = busy_cnt;
        @(negedge clk);
        bin   = val;
        start = 1'b1;
        @(posedge clk);
        #1;
        acc   = cyc;
        start = 1'b0;
        if (glitch) begin
            repeat (3) @(negedge clk);
            start = 1'b1;
            bin   = 26'd99;
            repeat (4) @(negedge clk);
            start = 1'b0;
        end
        for (int i = 0; i < 100; i++) begin
            if (done_cnt != d0) break;
            @(negedge clk);
            #1;
        end
        repeat (3) @(negedge clk);
        #1;
        chk({nm, " done_pulses"}, done_cnt - d0, 1);
        chk({nm, " write_count"}, wcnt - w0, 8);
        chk({nm, " busy_cycles"}, busy_cnt - b0, 35);
        chk({nm, " done_cycle"}, done_cyc - acc + 1, 35);
        chk({nm, " first_write_lat"}, wcyc[w0] - acc, 26);
        chk({nm, " idle_busy"}, {31'd0, busy}, 0);
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("%s sel%0d", nm, k), {29'd0, wsel[w0+k]}, k);
            chk($sformatf("%s num%0d", nm, k), {28'd0, wnum[w0+k]}, {28'd0, exp[4*k +: 4]});
        end
    endtask

    initial begin
        int w0, d0;
        reset  = 1'b0;
        start  = 1'b0;
        bin    = '0;
        start1 = 1'b0;
        bin1   = '0;
        #12;
        chk("rst busy",  {31'd0, busy},  0);
        chk("rst done",  {31'd0, done},  0);
        chk("rst write", {31'd0, write}, 0);
        chk("rst num",   {28'd0, num},   0);
        chk("rst sel",   {29'd0, sel},   0);
        @(negedge clk);
        reset = 1'b1;

        run_conv("zero", 26'd0,        32'h00000000, 1'b0);
        run_conv("mid",  26'd12345678, 32'h12345678, 1'b0);
        run_conv("max",  26'd67108863, 32'h67108863, 1'b0);
        run_conv("ign",  26'd42,       32'h00000042, 1'b1);

        // Abort mid-WRITE once digit 3 has been presented
        w0 = wcnt;
        d0 = done_cnt;
        @(negedge clk);
        bin   = 26'd12345678;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            #1;
            if (write && sel == 3'd3) break;
        end
        reset = 1'b0;
        #1;
        chk("abort busy",  {31'd0, busy},  0);
        chk("abort done",  {31'd0, done},  0);
        chk("abort write", {31'd0, write}, 0);
        chk("abort num",   {28'd0, num},   0);
        chk("abort sel",   {29'd0, sel},   0);
        repeat (5) @(negedge clk);
        #1;
        chk("abort writes", wcnt - w0, 4);
        chk("abort no_done", done_cnt - d0, 0);
        @(negedge clk);
        reset = 1'b1;
        run_conv("post", 26'd7, 32'h00000007, 1'b0);

        // Display scenario on the 27-bit instance
        @(negedge clk);
        bin1   = 27'd90817263;
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (done1_cnt != 0) break;
            @(negedge clk);
            #1;
        end
        chk("disp done", done1_cnt, 1);
        for (int k = 0; k < 8; k++) begin
            logic [31:0] dexp;
            dexp = 32'h90817263;
            chk($sformatf("disp pos%0d", k), {28'd0, disp[k]}, {28'd0, dexp[4*k +: 4]});
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bin_to_digit_writer.md
BIN_TO_DIGIT_WRITER -- requirements
Module: bin_to_digit_writer

Interface
REQ-001 The block SHALL have parameter IN_W, default 26, binary input width (max 67,108,863 fits 8 decimal digits).
REQ-002 The block SHALL have parameter DIGITS, default 8, number of decimal digits produced; 10^DIGITS > 2^IN_W SHALL hold.
REQ-003 The block SHALL have port clk, input, 1, single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-005 The block SHALL have port start, input, 1, request to convert bin; sampled only in IDLE.
REQ-006 The block SHALL have port bin, input, IN_W, unsigned binary value; captured on the accepting edge.
REQ-007 The block SHALL have port busy, output, 1, high in every state except IDLE.
REQ-008 The block SHALL have port done, output, 1, one-cycle pulse after the last digit write.
REQ-009 The block SHALL have port write, output, 1, one-cycle digit-write strobe to the downstream seven-segment display.
REQ-010 The block SHALL have port num, output, 4, BCD digit value; valid while write=1.
REQ-011 The block SHALL have port sel, output, 3, digit position (0 = least significant); valid while write=1.

Function
REQ-012 The block SHALL implement FSM states IDLE, CONVERT, WRITE, DONE.
REQ-013 In IDLE with start=1 at edge N, the block SHALL capture bin into a shift register, clear the BCD register, and enter CONVERT at edge N.
REQ-014 CONVERT SHALL last exactly IN_W cycles, running one double-dabble step per cycle.
REQ-015 Each CONVERT step SHALL add 3 to every BCD nibble >= 5, then shift {BCD, binary} left by one bit.
REQ-016 After the IN_W-th step the block SHALL enter WRITE with the final BCD result held unchanged.
REQ-017 WRITE SHALL last DIGITS cycles; in cycle k (k = 0..DIGITS-1), write=1, sel=k, num=BCD nibble k.
REQ-018 The first write SHALL be visible in the cycle after edge N+IN_W; the last write SHALL be visible in the cycle after edge N+IN_W+DIGITS-1.
REQ-019 DONE SHALL last one cycle with done=1 and write=0, then return to IDLE.
REQ-020 Total occupancy SHALL be IN_W+DIGITS+1 cycles; IN_W=26, DIGITS=8 gives 35 cycles.
REQ-021 start SHALL be ignored in CONVERT, WRITE and DONE, and bin changes SHALL be ignored after capture.
REQ-022 A start arriving in the DONE cycle SHALL be lost; the next start SHALL be accepted in IDLE one cycle later.
REQ-023 Outside WRITE, write SHALL be 0, while num and sel SHALL hold their last values.
REQ-024 All outputs SHALL be registered, with no combinational path from start or bin to any output.
REQ-025 bin=0 SHALL produce all-zero digits; no leading-zero blanking SHALL be applied, and every position SHALL be written.

Reset
REQ-026 reset=0 SHALL immediately force state=IDLE, busy=0, done=0, write=0, num=0, sel=0, and clear the internal registers, independent of clk.
REQ-027 A reset asserted mid-CONVERT or mid-WRITE SHALL abort the operation, with no further write or done pulses.
REQ-028 After reset deassertion, the first start SHALL be accepted on the first rising edge with reset=1 and start=1.

Verification
REQ-029 Scenario bin=0, start pulse -> 8 writes, sel 0..7, num all 0; done at cycle 35; busy high for 35 cycles.
REQ-030 Scenario bin=12345678 -> writes (sel,num) = (0,8),(1,7),(2,6),(3,5),(4,4),(5,3),(6,2),(7,1), then one done pulse.
REQ-031 Scenario bin=67108863 -> num sequence for sel 0..7 = 3,6,8,8,0,1,7,6.
REQ-032 Scenario: start with bin=42, then start=1 with bin=99 during CONVERT -> output digits 2,4,0,0,0,0,0,0 only; no second conversion.
REQ-033 Scenario: reset=0 asserted during WRITE after sel=3 -> all outputs 0 immediately; no further writes; next start with bin=7 -> digits 7,0,0,0,0,0,0,0.
REQ-034 Scenario: bench feeding the writes into the downstream seven-segment display with bin=90817263 -> the display's stored digits for positions 0..7 equal 3,6,2,7,1,8,0,9.
